// File: rtl/vector_mem_seq_pkg.sv
// Shared types and constants for the vector memory sequencer.
package vector_mem_pkg;

   // Data-memory beat width and the vector width built from eight beats.
   localparam int W     = 32;
   localparam int VW    = 8 * W;
   localparam int BEATS = 8;
   // Only seven lanes are buffered; the last lane is forwarded straight
   // from the memory read port during the drain cycle.
   localparam int LANES = BEATS - 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VSTORE = 2'd1,
      VLOAD  = 2'd2,
      VDRAIN = 2'd3
   } vmem_state_t;

   // True on the final beat of a vector transfer.
   function automatic logic is_last_beat(input logic [2:0] k);
      return k == 3'(BEATS - 1);
   endfunction

endpackage

// File: rtl/vector_mem_seq_if.sv
// Data-memory bus between the sequencer (master) and the memory (slave).
//
// Handshake: there is no backpressure. A cycle with mem_we=1 writes
// mem_wdata to mem_addr at the closing clock edge. A cycle with mem_re=1
// requests mem_addr; the slave presents the word on mem_rdata during the
// following cycle and holds it until the next read request completes.
interface vector_mem_seq_if #(
   parameter int N = 24,
   parameter int W = 32
);
   logic [N-1:0] mem_addr;
   logic         mem_we;
   logic         mem_re;
   logic [W-1:0] mem_wdata;
   logic [W-1:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_we,
      output mem_re,
      output mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_we,
      input  mem_re,
      input  mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/vector_mem_seq_vlane_buffer.sv
// Holds the seven vector-load lanes captured from the memory read port.
// Write is indexed by lane; clear is synchronous and has priority.
module vlane_buffer
   import vector_mem_pkg::*;
#(
   parameter int LANE_W = W
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    we,
   input  logic [2:0]              idx,
   input  logic [LANE_W-1:0]       wdata,
   output logic [LANES*LANE_W-1:0] lanes
);

   logic [LANES-1:0][LANE_W-1:0] lane_q;

   // Lane storage: clear wins over write; an index outside 0..6 writes nothing.
   always_ff @(posedge clk) begin
      if (clr) begin
         lane_q <= '0;
      end else if (we) begin
         for (int i = 0; i < LANES; i++) begin
            if (idx == 3'(i)) begin
               lane_q[i] <= wdata;
            end
         end
      end
   end

   assign lanes = lane_q;

endmodule

// File: rtl/vector_mem_seq.sv
// M-stage memory sequencer: passes scalar loads/stores straight through and
// serialises 8-beat vector loads/stores onto a single-word data memory,
// stalling the upstream pipeline while a vector transfer is in flight.
module vector_mem_seq #(
   parameter int N  = 24,
   parameter int W  = vector_mem_pkg::W,
   parameter int VW = vector_mem_pkg::VW
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        MemWriteM,
   input  logic                        MemtoRegM,
   input  logic                        vMemWriteM,
   input  logic                        vMemReadM,
   input  logic [N-1:0]                ALUResultM,
   input  logic [N-1:0]                WriteDataM,
   input  logic [VW-1:0]               vWriteDataM,
   output logic [N-1:0]                ReadDataM,
   output logic [VW-1:0]               vReadDataM,
   output logic                        vReadValidM,
   output logic                        StallM,
   vector_mem_seq_if.master            bus,
   output vector_mem_pkg::vmem_state_t dbg_state
);

   localparam int LANES = vector_mem_pkg::LANES;

   vector_mem_pkg::vmem_state_t state_q, state_d;
   logic [2:0]   k_q, k_d;
   logic [N-1:0] base_q, base_d;

   logic [N-1:0] beat_addr;
   logic [W-1:0] beat_wdata;
   logic [W-1:0] store_lane [8];

   logic [N-1:0] addr_c;
   logic         we_c;
   logic         re_c;
   logic [W-1:0] wdata_c;
   logic         stall_c;
   logic         vvalid_c;
   logic         lane_we;
   logic [2:0]   lane_idx;

   logic [LANES*W-1:0] lanes;

   // Split the vector store operand into per-beat words.
   for (genvar i = 0; i < 8; i++) begin : g_store_lane
      assign store_lane[i] = vWriteDataM[i*W +: W];
   end

   // Beat address wraps naturally at the N-bit address width.
   assign beat_addr  = base_q + N'(k_q);
   assign beat_wdata = store_lane[k_q];

   // State, beat counter and latched base address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= vector_mem_pkg::IDLE;
         k_q     <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         base_q  <= base_d;
      end
   end

   // Next state and raw (pre-reset-gating) memory/pipeline controls.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      base_d   = base_q;
      addr_c   = ALUResultM;
      we_c     = 1'b0;
      re_c     = 1'b0;
      wdata_c  = W'(WriteDataM);
      stall_c  = 1'b0;
      vvalid_c = 1'b0;
      lane_we  = 1'b0;
      lane_idx = k_q - 3'd1;

      case (state_q)
         vector_mem_pkg::IDLE: begin
            if (vMemWriteM || vMemReadM) begin
               // T0: latch the base and stall; no memory access this cycle.
               // A simultaneous store and load request is taken as a store.
               stall_c = 1'b1;
               base_d  = ALUResultM;
               k_d     = 3'd0;
               state_d = vMemWriteM ? vector_mem_pkg::VSTORE
                                    : vector_mem_pkg::VLOAD;
            end else begin
               we_c = MemWriteM;
               re_c = MemtoRegM;
            end
         end

         vector_mem_pkg::VSTORE: begin
            we_c    = 1'b1;
            addr_c  = beat_addr;
            wdata_c = beat_wdata;
            // The pipeline is released on the last beat so the next
            // instruction reaches M as the sequencer returns to IDLE.
            stall_c = !vector_mem_pkg::is_last_beat(k_q);
            k_d     = k_q + 3'd1;
            if (vector_mem_pkg::is_last_beat(k_q)) begin
               state_d = vector_mem_pkg::IDLE;
            end
         end

         vector_mem_pkg::VLOAD: begin
            re_c    = 1'b1;
            addr_c  = beat_addr;
            stall_c = 1'b1;
            // Read data lags its request by one cycle, so beat k delivers
            // the word requested by beat k-1.
            lane_we = (k_q != 3'd0);
            k_d     = k_q + 3'd1;
            if (vector_mem_pkg::is_last_beat(k_q)) begin
               state_d = vector_mem_pkg::VDRAIN;
            end
         end

         vector_mem_pkg::VDRAIN: begin
            // The eighth word is on mem_rdata now and is forwarded directly.
            vvalid_c = 1'b1;
            state_d  = vector_mem_pkg::IDLE;
         end

         default: begin
            state_d = vector_mem_pkg::IDLE;
         end
      endcase
   end

   vlane_buffer #(
      .LANE_W (W)
   ) u_lanes (
      .clk   (clk),
      .clr   (!rst_n),
      .we    (lane_we && rst_n),
      .idx   (lane_idx),
      .wdata (bus.mem_rdata),
      .lanes (lanes)
   );

   // Reset forces every strobe low regardless of state or inputs.
   assign bus.mem_addr  = addr_c;
   assign bus.mem_wdata = wdata_c;
   assign bus.mem_we    = we_c && rst_n;
   assign bus.mem_re    = re_c && rst_n;
   assign StallM        = stall_c && rst_n;
   assign vReadValidM   = vvalid_c && rst_n;

   assign ReadDataM  = bus.mem_rdata[N-1:0];
   assign vReadDataM = {(vReadValidM ? bus.mem_rdata : {W{1'b0}}), lanes};
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_vector_mem_seq.sv
// Bench for vector_mem_seq: directed spec scenarios, then random scalar and
// vector traffic scored cycle by cycle against a transaction-level model.
module tb_vector_mem_seq;

   localparam int N  = 24;
   localparam int W  = 32;
   localparam int VW = 256;

   logic          clk;
   logic          rst_n;
   logic          MemWriteM;
   logic          MemtoRegM;
   logic          vMemWriteM;
   logic          vMemReadM;
   logic [N-1:0]  ALUResultM;
   logic [N-1:0]  WriteDataM;
   logic [VW-1:0] vWriteDataM;
   logic [N-1:0]  ReadDataM;
   logic [VW-1:0] vReadDataM;
   logic          vReadValidM;
   logic          StallM;
   vector_mem_pkg::vmem_state_t dbg_state;

   vector_mem_seq_if #(.N(N), .W(W)) bus ();

   vector_mem_seq #(.N(N), .W(W), .VW(VW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .MemWriteM   (MemWriteM),
      .MemtoRegM   (MemtoRegM),
      .vMemWriteM  (vMemWriteM),
      .vMemReadM   (vMemReadM),
      .ALUResultM  (ALUResultM),
      .WriteDataM  (WriteDataM),
      .vWriteDataM (vWriteDataM),
      .ReadDataM   (ReadDataM),
      .vReadDataM  (vReadDataM),
      .vReadValidM (vReadValidM),
      .StallM      (StallM),
      .bus         (bus),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory responder ----------------
   logic [W-1:0] resp_mem [logic [N-1:0]];

   function automatic logic [W-1:0] resp_rd(input logic [N-1:0] a);
      if (resp_mem.exists(a)) return resp_mem[a];
      return '0;
   endfunction

   always @(posedge clk) begin
      if (bus.mem_re) bus.mem_rdata <= resp_rd(bus.mem_addr);
      if (bus.mem_we) resp_mem[bus.mem_addr] = bus.mem_wdata;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic          we;
      logic          re;
      logic          stall;
      logic          vvalid;
      logic          chk_addr;
      logic [N-1:0]  addr;
      logic          chk_wdata;
      logic [W-1:0]  wdata;
      logic          chk_vdata;
      logic [VW-1:0] vdata;
      logic          chk_rd;
      logic [N-1:0]  rd;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   failed = 0;

   // Model state: memory contents and the lane buffer as seen in IDLE.
   logic [W-1:0]  model_mem [logic [N-1:0]];
   logic [VW-1:0] model_lanes;
   logic          pend_rd;
   logic [N-1:0]  pend_val;
   logic [VW-1:0] last_vread;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] model_rd(input logic [N-1:0] a);
      if (model_mem.exists(a)) return model_mem[a];
      return '0;
   endfunction

   always @(negedge clk) begin : compare
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("mem_we", VW'(bus.mem_we), VW'(e.we));
         check("mem_re", VW'(bus.mem_re), VW'(e.re));
         check("StallM", VW'(StallM), VW'(e.stall));
         check("vReadValidM", VW'(vReadValidM), VW'(e.vvalid));
         check("ReadDataM_alias", VW'(ReadDataM), VW'(bus.mem_rdata[N-1:0]));
         if (e.chk_addr)  check("mem_addr", VW'(bus.mem_addr), VW'(e.addr));
         if (e.chk_wdata) check("mem_wdata", VW'(bus.mem_wdata), VW'(e.wdata));
         if (e.chk_vdata) check("vReadDataM", vReadDataM, e.vdata);
         if (e.chk_rd)    check("scalar_load", VW'(ReadDataM), VW'(e.rd));
      end
   end

   // ---------------- driver tasks ----------------
   function automatic exp_t new_exp();
      exp_t e;
      e = '{default: '0};
      e.chk_rd = pend_rd;
      e.rd     = pend_val;
      pend_rd  = 1'b0;
      return e;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < 8; i++) v[W*i +: W] = $urandom;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Scalar inputs that the sequencer must ignore outside IDLE.
   task automatic noise();
      MemWriteM  = 1'($urandom_range(0, 1));
      MemtoRegM  = 1'($urandom_range(0, 1));
      vMemWriteM = 1'($urandom_range(0, 1));
      vMemReadM  = 1'($urandom_range(0, 1));
      ALUResultM = N'($urandom);
      WriteDataM = N'($urandom);
   endtask

   // Drive one IDLE scalar cycle (no tick) and queue its expectation.
   task automatic idle_cycle(input logic wr, input logic rd, input logic [N-1:0] a, input logic [N-1:0] d);
      exp_t e;
      logic [W-1:0] old;
      MemWriteM   = wr;
      MemtoRegM   = rd;
      vMemWriteM  = 1'b0;
      vMemReadM   = 1'b0;
      ALUResultM  = a;
      WriteDataM  = d;
      vWriteDataM = rand_vec();
      e = new_exp();
      e.we        = wr;
      e.re        = rd;
      e.chk_addr  = 1'b1;
      e.addr      = a;
      e.chk_wdata = 1'b1;
      e.wdata     = {8'h00, d};
      e.chk_vdata = 1'b1;
      e.vdata     = model_lanes;
      if (rd) begin
         old      = model_rd(a);
         pend_rd  = 1'b1;
         pend_val = old[N-1:0];
      end
      if (wr) model_mem[a] = {8'h00, d};
      exp_q.push_back(e);
   endtask

   task automatic scalar_op(input logic wr, input logic rd, input logic [N-1:0] a, input logic [N-1:0] d);
      tick();
      idle_cycle(wr, rd, a, d);
   endtask

   task automatic vstore_op(input logic [N-1:0] base, input logic [VW-1:0] data, input logic both);
      exp_t e;
      logic [N-1:0] a;
      tick();
      noise();
      vMemWriteM  = 1'b1;
      vMemReadM   = both;
      ALUResultM  = base;
      vWriteDataM = data;
      e = new_exp();
      e.stall     = 1'b1;
      e.chk_vdata = 1'b1;
      e.vdata     = model_lanes;
      exp_q.push_back(e);
      for (int k = 0; k < 8; k++) begin
         tick();
         noise();
         a = base + N'(k);
         e = new_exp();
         e.we        = 1'b1;
         e.chk_addr  = 1'b1;
         e.addr      = a;
         e.chk_wdata = 1'b1;
         e.wdata     = data[W*k +: W];
         e.stall     = (k < 7);
         model_mem[a] = data[W*k +: W];
         exp_q.push_back(e);
      end
   endtask

   // rst_at < 0: full load; otherwise reset is asserted during beat rst_at.
   task automatic vload_op(input logic [N-1:0] base, input int rst_at);
      exp_t e;
      logic [VW-1:0] v;
      tick();
      noise();
      vMemWriteM  = 1'b0;
      vMemReadM   = 1'b1;
      ALUResultM  = base;
      vWriteDataM = rand_vec();
      e = new_exp();
      e.stall     = 1'b1;
      e.chk_vdata = 1'b1;
      e.vdata     = model_lanes;
      exp_q.push_back(e);
      for (int k = 0; k < 8; k++) begin
         tick();
         noise();
         if (k == rst_at) begin
            rst_n = 1'b0;
            e = new_exp();
            exp_q.push_back(e);
            tick();
            model_lanes = '0;
            idle_cycle(1'b0, 1'b0, N'($urandom), N'($urandom));
            return;
         end
         e = new_exp();
         e.re       = 1'b1;
         e.chk_addr = 1'b1;
         e.addr     = base + N'(k);
         e.stall    = 1'b1;
         exp_q.push_back(e);
      end
      tick();
      noise();
      for (int i = 0; i < 8; i++) v[W*i +: W] = model_rd(base + N'(i));
      e = new_exp();
      e.vvalid    = 1'b1;
      e.chk_vdata = 1'b1;
      e.vdata     = v;
      exp_q.push_back(e);
      model_lanes = v;
      model_lanes[VW-1 -: W] = '0;
      @(negedge clk);
      #1;
      last_vread = vReadDataM;
   endtask

   // ---------------- stimulus ----------------
   initial begin : watchdog
      #1_000_000;
      failed++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin : main
      logic [VW-1:0] v;
      logic [N-1:0]  b;
      int            r;
      int            rb;

      rst_n       = 1'b0;
      pend_rd     = 1'b0;
      pend_val    = '0;
      model_lanes = '0;
      last_vread  = '0;
      noise();
      vWriteDataM = '0;
      for (int i = 0; i < 8; i++) begin
         model_mem[N'(24'h200 + i)] = W'(32'hA0 + i);
         resp_mem[N'(24'h200 + i)]  = W'(32'hA0 + i);
      end

      // Reset held for three cycles with vector requests present.
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         tick();
         rst_n = 1'b0;
         noise();
         vMemWriteM = 1'b1;
         e = new_exp();
         exp_q.push_back(e);
      end

      // Scalar store passes straight through.
      scalar_op(1'b1, 1'b0, 24'h000010, 24'hABCDEF);
      @(negedge clk);
      #1;
      check("lit_scalar_wdata", VW'(bus.mem_wdata), VW'(32'h00ABCDEF));
      check("lit_scalar_addr", VW'(bus.mem_addr), VW'(24'h000010));
      check("lit_reset_buffer", vReadDataM, '0);

      // Vector store, lane i = 0x11111111*i.
      for (int i = 0; i < 8; i++) v[W*i +: W] = 32'h11111111 * i;
      vstore_op(24'h000100, v, 1'b0);
      scalar_op(1'b0, 1'b0, 24'h000000, 24'h000000);
      for (int i = 0; i < 8; i++)
         check("lit_vstore_mem", VW'(resp_rd(N'(24'h100 + i))), VW'(32'h11111111 * i));

      // Vector load of preloaded words.
      vload_op(24'h000200, -1);
      check("lit_vload_data", last_vread,
            256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0);
      check("lit_vload_state", VW'(dbg_state), VW'(vector_mem_pkg::VDRAIN));

      // Wrapping vector store.
      for (int i = 0; i < 8; i++) v[W*i +: W] = 32'h5A5A0000 + i;
      vstore_op(24'hFFFFFE, v, 1'b0);
      scalar_op(1'b0, 1'b0, 24'h000000, 24'h000000);
      check("lit_wrap_fffffe", VW'(resp_rd(24'hFFFFFE)), VW'(32'h5A5A0000));
      check("lit_wrap_ffffff", VW'(resp_rd(24'hFFFFFF)), VW'(32'h5A5A0001));
      check("lit_wrap_000000", VW'(resp_rd(24'h000000)), VW'(32'h5A5A0002));
      check("lit_wrap_000005", VW'(resp_rd(24'h000005)), VW'(32'h5A5A0007));

      // Reset during load beat 3.
      vload_op(24'h000200, 3);
      @(negedge clk);
      #1;
      check("lit_rst_buffer", vReadDataM, '0);
      check("lit_rst_stall", VW'(StallM), '0);
      check("lit_rst_re", VW'(bus.mem_re), '0);
      check("lit_rst_state", VW'(dbg_state), VW'(vector_mem_pkg::IDLE));

      // Store and load requested together: store sequence only.
      for (int i = 0; i < 8; i++) v[W*i +: W] = 32'h11111111 * i;
      vstore_op(24'h000100, v, 1'b1);

      // Scalar load of the word stored first.
      scalar_op(1'b0, 1'b1, 24'h000010, 24'h000000);
      scalar_op(1'b0, 1'b0, 24'h000000, 24'h000000);
      @(negedge clk);
      #1;
      check("lit_scalar_load", VW'(ReadDataM), VW'(24'hABCDEF));

      // Random traffic, back to back.
      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 9);
         if ($urandom_range(0, 7) == 0) b = N'(24'hFFFFF8 + $urandom_range(0, 7));
         else                           b = N'($urandom_range(0, 48));
         if (r < 4) begin
            scalar_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      N'($urandom_range(0, 63)), N'($urandom));
         end else if (r < 7) begin
            vstore_op(b, rand_vec(), 1'($urandom_range(0, 1)));
         end else begin
            rb = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
            vload_op(b, rb);
         end
      end

      scalar_op(1'b0, 1'b0, 24'h000000, 24'h000000);
      @(negedge clk);
      #1;
      check("queue_drained", VW'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/vector_mem_seq.md
VECTOR_MEM_SEQ -- requirements
Module: vector_mem_seq

Interface
REQ-001 SHALL have parameter N, default 24, scalar datapath/address width.
REQ-002 SHALL have parameter W, default 32, data-memory beat width.
REQ-003 SHALL have parameter VW, default 256, vector width, with VW = 8*W.
REQ-004 clk  in  1  single clock, all state on posedge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 MemWriteM  in  1  scalar store in M stage.
REQ-007 MemtoRegM  in  1  scalar load in M stage.
REQ-008 vMemWriteM  in  1  vector store in M stage.
REQ-009 vMemReadM  in  1  vector load in M stage.
REQ-010 ALUResultM  in  N  memory word address (scalar or vector base).
REQ-011 WriteDataM  in  N  scalar store data.
REQ-012 vWriteDataM  in  VW  vector store data.
REQ-013 mem_addr  out  N  data-memory word address.
REQ-014 mem_we  out  1  data-memory write enable.
REQ-015 mem_re  out  1  data-memory read enable; read data valid on mem_rdata the next cycle.
REQ-016 mem_wdata  out  W  data-memory write data.
REQ-017 mem_rdata  in  W  data-memory read data.
REQ-018 ReadDataM  out  N  scalar load data, equal to mem_rdata[N-1:0].
REQ-019 vReadDataM  out  VW  assembled vector load data.
REQ-020 vReadValidM  out  1  vReadDataM valid this cycle.
REQ-021 StallM  out  1  holds F/D/E/M pipeline registers while high.

Function
REQ-022 States SHALL be IDLE, VSTORE, VLOAD, VDRAIN; beat counter k is 3 bits; base address is latched.
REQ-023 In IDLE with no vector op: mem_addr=ALUResultM, mem_we=MemWriteM, mem_re=MemtoRegM, mem_wdata=WriteDataM zero-extended to W, StallM=0.
REQ-024 In IDLE with vMemWriteM=1 (cycle T0): StallM=1, no memory access, latch base=ALUResultM, k=0, next state VSTORE.
REQ-025 In IDLE with vMemReadM=1 (T0): same as REQ-024, next state VLOAD.
REQ-026 vMemWriteM and vMemReadM both high SHALL be treated as vector store.
REQ-027 VSTORE beat k (T1..T8): mem_we=1, mem_addr=base+k, mem_wdata=vWriteDataM[W*k+W-1:W*k]; StallM=1 for k<7, StallM=0 at k=7; after k=7 next state IDLE.
REQ-028 VLOAD beat k (T1..T8): mem_re=1, mem_addr=base+k, StallM=1; mem_rdata in the next cycle SHALL be captured into lane k-1 buffer; after k=7 next state VDRAIN.
REQ-029 VDRAIN (T9): no memory access, StallM=0, vReadValidM=1, vReadDataM={mem_rdata, lanes 6..0}; next state IDLE.
REQ-030 vReadValidM SHALL be 0 outside VDRAIN; vReadDataM SHALL equal the lane buffer with zero top lane outside VDRAIN.
REQ-031 Address arithmetic base+k SHALL wrap modulo 2^N.
REQ-032 Scalar inputs SHALL be ignored outside IDLE.
REQ-033 Back-to-back vector ops SHALL be accepted: an op presented in IDLE the cycle after completion starts a new T0.
REQ-034 Latency: vector store 9 cycles, vector load 10 cycles, scalar 1 cycle (no stall).

Reset
REQ-035 While rst_n=0 at a posedge: state IDLE, k=0, base=0, lane buffer=0.
REQ-036 While rst_n=0: mem_we=0, mem_re=0, StallM=0, vReadValidM=0, regardless of inputs.
REQ-037 Reset mid-operation SHALL abort with no further memory writes; partially issued beats are not undone.

Structure
REQ-038 Package vector_mem_pkg SHALL hold the state enum, W, VW, and BEATS=8.
REQ-039 Sub-module vlane_buffer SHALL hold the 7 captured lanes with indexed write and clear.

Verification
REQ-040 Scalar store: MemWriteM=1, ALUResultM=0x000010, WriteDataM=0xABCDEF -> same cycle mem_we=1, mem_addr=0x10, mem_wdata=0x00ABCDEF, StallM=0.
REQ-041 Vector store: base=0x000100, lane i = 0x1111_1111*i -> mem_we beats T1..T8 at 0x100..0x107 with lane data in order, StallM high T0..T7, low T8.
REQ-042 Vector load: memory 0x200..0x207 holds 0xA0..0xA7 -> vReadValidM=1 only at T9, vReadDataM lane i = 0xA0+i, StallM low at T9.
REQ-043 Wrap: vector store base=0xFFFFFE -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000..0x000005.
REQ-044 Reset at VLOAD beat 3 -> next cycle IDLE, mem_re=0, StallM=0, buffer all zero.
REQ-045 vMemWriteM=vMemReadM=1 -> store sequence of REQ-041, no mem_re asserted.
